bus_if: RTL and testbench

BUS_IF -- requirements
Module: bus_if

---
 rtl/bus_if_if.sv | 28 ++
 rtl/bus_if.sv | 141 ++++++++++++++
 tb/tb_bus_if.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_if_if.sv
// Core-side handshake and external strobe signals of the bus bridge.
// The DUT uses the slave modport; the requesting core / environment uses master.
interface bus_if_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  done;
  logic                  err;
  logic                  busy;
  logic                  rd;
  logic                  wr;
  logic                  ready;

  modport slave (
    input  req, we, req_addr, wdata, ready,
    output rdata, done, err, busy, rd, wr
  );

  modport master (
    output req, we, req_addr, wdata, ready,
    input  rdata, done, err, busy, rd, wr
  );
endinterface

// File: rtl/bus_if.sv
// Two-state bridge from a core request port to an external strobed bus with a
// shared tri-state data line, per-access wait counting and optional timeout.
module bus_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_if_if.slave              core,
  output tri  [ADDR_WIDTH-1:0] addr,
  inout  tri  [DATA_WIDTH-1:0] data
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  timeout_s;
  logic                  busy_s;
  logic                  rd_s;
  logic                  wr_s;

  // Timeout fires on the edge that would otherwise start wait cycle TIMEOUT+1;
  // a coincident ready wins because it is checked first below.
  assign timeout_s = (TIMEOUT > 0) && (cnt_q == CNT_LAST) && !core.ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      addr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
      rdata_q <= {DATA_WIDTH{1'b0}};
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = {CW{1'b0}};
        if (core.req) begin
          state_d = ACCESS;
          addr_d  = core.req_addr;
          wdata_d = core.wdata;
          we_d    = core.we;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (core.ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!we_q) begin
            rdata_d = data;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (timeout_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes and busy decoded from registered state
  always_comb begin
    busy_s = 1'b0;
    rd_s   = 1'b0;
    wr_s   = 1'b0;
    case (state_q)
      IDLE: begin
        busy_s = 1'b0;
      end
      ACCESS: begin
        busy_s = 1'b1;
        rd_s   = ~we_q;
        wr_s   = we_q;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign core.busy  = busy_s;
  assign core.rd    = rd_s;
  assign core.wr    = wr_s;
  assign core.done  = done_q;
  assign core.err   = err_q;
  assign core.rdata = rdata_q;

  // The bus is released whenever no strobe is active, so reset floats it at once.
  assign addr = (rd_s | wr_s) ? addr_q  : {ADDR_WIDTH{1'bz}};
  assign data = wr_s          ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_if.sv
// Self-checking bench for bus_if: table of accesses plus hand-written
// back-to-back, idle-ready and asynchronous-reset sequences.
module tb_bus_if;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;

  tri [AW-1:0] addr;
  tri [DW-1:0] data;

  logic          slv_drv;
  logic [DW-1:0] slv_val;

  assign data = slv_drv ? slv_val : {DW{1'bz}};

  bus_if_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

  bus_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (bif.slave),
    .addr (addr),
    .data (data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] sd;
    int            waits;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest issued access
  always @(negedge clk) begin
    if (rst && bif.done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'(bif.done), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_err", 64'(bif.err), 64'(e.err));
        chk("sb_rdata", 64'(bif.rdata), 64'(e.rdata));
      end
    end
  end

  // One access from req to the cycle after done; called on a negedge
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n_strobe = 0;
    int   exp_strobe;
    exp_strobe = (v.waits < TMO) ? v.waits + 1 : TMO;
    bif.req      = 1'b1;
    bif.we       = v.we;
    bif.req_addr = v.a;
    bif.wdata    = v.wd;
    e.err   = v.exp_err;
    e.rdata = v.exp_rdata;
    sb_q.push_back(e);
    @(negedge clk);
    bif.req      = 1'b0;
    bif.we       = ~v.we;
    bif.req_addr = ~v.a;
    bif.wdata    = ~v.wd;
    for (int k = 0; k < TMO; k++) begin
      chk("acc_busy", 64'(bif.busy), 64'd1);
      chk("acc_rd", 64'(bif.rd), 64'(!v.we));
      chk("acc_wr", 64'(bif.wr), 64'(v.we));
      chk("acc_addr", 64'(addr), 64'(v.a));
      chk("acc_done_low", 64'(bif.done), 64'd0);
      if (v.we) chk("acc_wdata_bus", 64'(data), 64'(v.wd));
      if (bif.rd | bif.wr) n_strobe++;
      slv_drv   = !v.we;
      slv_val   = v.sd;
      bif.ready = (k == v.waits);
      @(negedge clk);
      if (k == v.waits) break;
    end
    bif.ready = 1'b0;
    slv_drv   = 1'b0;
    chk("strobe_cycles", 64'(n_strobe), 64'(exp_strobe));
    chk("done_pulse", 64'(bif.done), 64'd1);
    chk("done_busy_low", 64'(bif.busy), 64'd0);
    chk("done_strobes_low", 64'(bif.rd | bif.wr), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(bif.done), 64'd0);
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = '{1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0,  1'b0, 32'hDEAD_BEEF};
    vt[1] = '{1'b1, 32'h0000_0200, 32'h1234_5678, 32'h0,         3,  1'b0, 32'hDEAD_BEEF};
    vt[2] = '{1'b0, 32'h0000_0300, 32'h0,         32'hBAAD_F00D, 99, 1'b1, 32'hDEAD_BEEF};
    vt[3] = '{1'b0, 32'h0000_0304, 32'h0,         32'hCAFE_F00D, 15, 1'b0, 32'hCAFE_F00D};
    vt[4] = '{1'b1, 32'h0000_0400, 32'hA5A5_5A5A, 32'h0,         99, 1'b1, 32'hCAFE_F00D};
    vt[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0001, 1,  1'b0, 32'h0000_0001};
    vt[6] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0,         15, 1'b0, 32'h0000_0001};

    rst          = 1'b0;
    bif.req      = 1'b0;
    bif.we       = 1'b0;
    bif.req_addr = 32'h0;
    bif.wdata    = 32'h0;
    bif.ready    = 1'b0;
    slv_drv      = 1'b0;
    slv_val      = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bif.busy), 64'd0);
    chk("rst_rd", 64'(bif.rd), 64'd0);
    chk("rst_wr", 64'(bif.wr), 64'd0);
    chk("rst_done", 64'(bif.done), 64'd0);
    chk("rst_err", 64'(bif.err), 64'd0);
    chk("rst_rdata", 64'(bif.rdata), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // ready while idle must not start or complete anything
    bif.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready_busy", 64'(bif.busy), 64'd0);
      chk("idle_ready_done", 64'(bif.done), 64'd0);
    end
    bif.ready = 1'b0;

    // back-to-back reads with req held high
    begin
      exp_t e;
      bif.req = 1'b1; bif.we = 1'b0; bif.req_addr = 32'h0000_0A00;
      e.err = 1'b0; e.rdata = 32'h1111_2222; sb_q.push_back(e);
      @(negedge clk);
      chk("b2b_busy1", 64'(bif.busy), 64'd1);
      chk("b2b_addr1", 64'(addr), 64'h0000_0A00);
      chk("b2b_rd1", 64'(bif.rd), 64'd1);
      bif.req_addr = 32'h0000_0B00;
      slv_drv = 1'b1; slv_val = 32'h1111_2222; bif.ready = 1'b1;
      e.err = 1'b0; e.rdata = 32'h3333_4444; sb_q.push_back(e);
      @(negedge clk);
      slv_drv = 1'b0;
      chk("b2b_done1", 64'(bif.done), 64'd1);
      chk("b2b_busy_done1", 64'(bif.busy), 64'd0);
      @(negedge clk);
      chk("b2b_busy2", 64'(bif.busy), 64'd1);
      chk("b2b_addr2", 64'(addr), 64'h0000_0B00);
      chk("b2b_rd2", 64'(bif.rd), 64'd1);
      bif.req = 1'b0; slv_drv = 1'b1; slv_val = 32'h3333_4444;
      @(negedge clk);
      slv_drv = 1'b0; bif.ready = 1'b0;
      chk("b2b_done2", 64'(bif.done), 64'd1);
      chk("b2b_busy_done2", 64'(bif.busy), 64'd0);
      @(negedge clk);
      chk("b2b_idle", 64'(bif.busy), 64'd0);
    end

    // asynchronous reset in the middle of a write
    bif.req = 1'b1; bif.we = 1'b1; bif.req_addr = 32'h0000_0C00; bif.wdata = 32'h5555_AAAA;
    @(negedge clk);
    bif.req = 1'b0;
    chk("arst_wr_before", 64'(bif.wr), 64'd1);
    chk("arst_data_before", 64'(data), 64'h5555_AAAA);
    #2 rst = 1'b0;
    #1;
    chk("arst_wr", 64'(bif.wr), 64'd0);
    chk("arst_rd", 64'(bif.rd), 64'd0);
    chk("arst_busy", 64'(bif.busy), 64'd0);
    chk("arst_rdata", 64'(bif.rdata), 64'd0);
    @(negedge clk);
    chk("arst_no_done", 64'(bif.done), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_no_done_after", 64'(bif.done), 64'd0);
    begin
      vec_t v;
      v = '{1'b0, 32'h0000_0500, 32'h0, 32'h1357_9BDF, 2, 1'b0, 32'h1357_9BDF};
      run_vec(v);
    end

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
